bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one system bus slave port among four bus masters: CPU instruction-fetch bus_if, CPU data bus_if, DMA, debug.
- Masters raise req and wait for a registered grant (their bus_get). The granted master's address/control/write data are muxed onto the slave side.
- s_ready and read data are returned to the owner only.
- Round-robin fairness. Timeout watchdog so a dead slave cannot hang the pipeline stall.

Parameters:
ADDR_W, 30, word-address width (WordAddrBus)
DATA_W, 32, data width (WordDataBus)
TIMEOUT, 255, max cycles owner may hold s_as high without s_ready; 0 disables watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m_req  in  4  per-master bus request, bit i = master i
m_addr  in  4*ADDR_W  master i address in bits [i*ADDR_W +: ADDR_W]
m_as  in  4  per-master address strobe
m_rw  in  4  per-master direction, 0=read 1=write
m_wr_data  in  4*DATA_W  master i write data in bits [i*DATA_W +: DATA_W]
m_grnt  out  4  registered one-hot grant (bus_get of each master)
m_ready  out  4  per-master transfer-complete
m_err  out  4  per-master timeout error pulse
m_rd_data  out  DATA_W  read data, broadcast to all masters
s_addr  out  ADDR_W  slave address
s_as  out  1  slave address strobe
s_rw  out  1  slave direction
s_wr_data  out  DATA_W  slave write data
s_ready  in  1  slave transfer-complete
s_rd_data  in  DATA_W  slave read data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: m_grnt=0, owner_valid=0, last_owner=3 so master 0 has first priority, watchdog count=0.
  - All combinational outputs then read idle values: s_as=0, s_addr=0, s_rw=0, s_wr_data=0, m_ready=0, m_err=0, m_rd_data=0.
- State: owner_valid (1b), owner (2b), last_owner (2b), wd_cnt (8b min, sized for TIMEOUT).
  - States are IDLE (owner_valid=0) and OWNED (owner_valid=1).
- Arbitration cycle: any cycle where owner_valid=0, or m_req[owner]=0.
  - Search order is last_owner+1, +2, +3, last_owner, mod 4. First requester found wins.
  - At the next edge: owner<=winner, last_owner<=winner, m_grnt<=onehot(winner), owner_valid<=1.
  - If there is no requester: owner_valid<=0 and m_grnt<=0.
- Grant latency: 1 cycle from req rising (IDLE) to m_grnt.
- Handover: owner dropping req in cycle t with another req pending gives the new grant at t+1. There is no dead cycle.
  - The old owner's grant drops at the same edge.
- Ownership: the owner keeps the grant while its req stays high. There is no preemption, and the owner may issue multiple transfers.
- Slave mux (combinational):
  - When owner_valid: s_addr/s_as/s_rw/s_wr_data = owner's fields.
  - Otherwise all are zero.
- Return path:
  - m_ready[owner] = s_ready & owner_valid & s_as. Other bits are 0.
  - m_rd_data = s_rd_data while owner_valid, else 0.
- s_ready arriving while s_as=0 is ignored.
- Watchdog:
  - wd_cnt clears when TIMEOUT=0, !owner_valid, !s_as, or s_ready. Otherwise it increments.
  - Expiry: when wd_cnt==TIMEOUT-1 and s_as high without s_ready, the arbiter pulses m_err[owner] and m_ready[owner] for that cycle and forces m_rd_data=0.
  - wd_cnt then clears. Ownership is unchanged; the master is expected to drop req.
- Simultaneous events:
  - s_ready in the same cycle as owner drops req: completion is still delivered to the old owner, and the handover proceeds.
  - rst has priority over everything.
- Reset mid-transfer: the grant drops at the next edge and s_as goes 0. The in-flight slave transfer is abandoned and the slave must tolerate an aborted strobe.
- Masters not granted must not see m_ready or m_err. One-hot m_grnt is an invariant: never more than one bit set.

Test Plan:
- Reset: rst=1 for 2 cycles with all m_req=1 -> m_grnt=0000, s_as=0, s_addr=0. After release, m_grnt=0001 one cycle later.
- Single master: m_req=0010, m1 addr=0x100, rw=0, as=1; s_ready pulse with s_rd_data=0xDEADBEEF -> m_grnt=0010 at +1 cycle, s_addr=0x100, m_ready=0010 for that cycle only, m_rd_data=0xDEADBEEF.
- Round-robin: all four request from IDLE, each drops req after one completed transfer -> grants in order 0,1,2,3, then 0 again (if re-requested), each handover back-to-back.
- Hold: m0 owns and keeps req high across 3 transfers while m2 requests -> m2 is not granted until m0 drops req. Then m_grnt=0100 on the next cycle.
- Timeout: TIMEOUT=8, owner m3 holds s_as, s_ready never asserted -> on the 8th cycle m_err=1000 and m_ready=1000 for one cycle, m_rd_data=0. No error with TIMEOUT=0.
- Mid-transfer reset: rst asserted while m1 owns with s_as high -> m_grnt=0000 and s_as=0 the following cycle. Next grant goes to master 0 priority after reset.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-master round-robin arbiter in front of a single bus slave port.
// It registers a one-hot grant, muxes the owner onto the slave and recovers from a slave that never answers.
module bus_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            m_req,
    input  logic [4*ADDR_W-1:0]   m_addr,
    input  logic [3:0]            m_as,
    input  logic [3:0]            m_rw,
    input  logic [4*DATA_W-1:0]   m_wr_data,
    output logic [3:0]            m_grnt,
    output logic [3:0]            m_ready,
    output logic [3:0]            m_err,
    output logic [DATA_W-1:0]     m_rd_data,
    output logic [ADDR_W-1:0]     s_addr,
    output logic                  s_as,
    output logic                  s_rw,
    output logic [DATA_W-1:0]     s_wr_data,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rd_data
);

    localparam int WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    logic            owner_valid_q, owner_valid_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_owner_q, last_owner_d;
    logic [3:0]      m_grnt_q, m_grnt_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    logic [ADDR_W-1:0] addr_arr [4];
    logic [DATA_W-1:0] wdata_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = m_wr_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Rotating search starting just after the last winner; the last winner is tried last.
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;
    always_comb begin
        winner = last_owner_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_owner_q + 2'(k);
            if (!found && m_req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    logic arb_cycle;
    assign arb_cycle = !owner_valid_q || !m_req[owner_q];

    always_comb begin
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        m_grnt_d      = m_grnt_q;
        if (arb_cycle) begin
            if (found) begin
                owner_valid_d = 1'b1;
                owner_d       = winner;
                last_owner_d  = winner;
                m_grnt_d      = 4'b0001 << winner;
            end else begin
                owner_valid_d = 1'b0;
                m_grnt_d      = 4'b0000;
            end
        end
    end

    assign s_as      = owner_valid_q ? m_as[owner_q]      : 1'b0;
    assign s_rw      = owner_valid_q ? m_rw[owner_q]      : 1'b0;
    assign s_addr    = owner_valid_q ? addr_arr[owner_q]  : '0;
    assign s_wr_data = owner_valid_q ? wdata_arr[owner_q] : '0;

    // Expiry completes the stuck transfer with an error so the owner's stall is released.
    logic wd_expire;
    assign wd_expire = (TIMEOUT != 0) && owner_valid_q && s_as && !s_ready && (wd_cnt_q == WD_LAST);

    always_comb begin
        if ((TIMEOUT == 0) || !owner_valid_q || !s_as || s_ready || wd_expire) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_return
            logic is_owner;
            assign is_owner    = owner_valid_q && (owner_q == 2'(gi));
            assign m_ready[gi] = is_owner && s_as && (s_ready || wd_expire);
            assign m_err[gi]   = is_owner && wd_expire;
        end
    endgenerate

    assign m_rd_data = (owner_valid_q && !wd_expire) ? s_rd_data : '0;
    assign m_grnt    = m_grnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_valid_q <= 1'b0;
            owner_q       <= 2'd0;
            last_owner_q  <= 2'd3;
            m_grnt_q      <= 4'b0000;
            wd_cnt_q      <= '0;
        end else begin
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            m_grnt_q      <= m_grnt_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single master, round-robin, hold, watchdog and mid-transfer reset.
// A second instance with TIMEOUT=0 shares the stimulus to show the watchdog can be disabled.
module tb_bus_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      m_req, m_as, m_rw;
    logic [4*AW-1:0] m_addr;
    logic [4*DW-1:0] m_wr_data;
    logic            s_ready;
    logic [DW-1:0]   s_rd_data;

    logic [3:0]      m_grnt, m_ready, m_err;
    logic [DW-1:0]   m_rd_data, s_wr_data;
    logic [AW-1:0]   s_addr;
    logic            s_as, s_rw;

    logic [3:0]      z_grnt, z_ready, z_err;
    logic [DW-1:0]   z_rd_data, z_wr_data;
    logic [AW-1:0]   z_addr;
    logic            z_as, z_rw;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_as(m_as), .m_rw(m_rw),
        .m_wr_data(m_wr_data), .m_grnt(m_grnt), .m_ready(m_ready), .m_err(m_err),
        .m_rd_data(m_rd_data), .s_addr(s_addr), .s_as(s_as), .s_rw(s_rw),
        .s_wr_data(s_wr_data), .s_ready(s_ready), .s_rd_data(s_rd_data)
    );

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut_nowd (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_as(m_as), .m_rw(m_rw),
        .m_wr_data(m_wr_data), .m_grnt(z_grnt), .m_ready(z_ready), .m_err(z_err),
        .m_rd_data(z_rd_data), .s_addr(z_addr), .s_as(z_as), .s_rw(z_rw),
        .s_wr_data(z_wr_data), .s_ready(s_ready), .s_rd_data(s_rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-18s got=%0h ok", tag, got);
        end else begin
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_req = 4'hF; m_as = 4'hF; m_rw = 4'h0;
        m_addr = '0; m_wr_data = '0;
        s_ready = 1'b1; s_rd_data = 32'hAAAA5555;
        for (int i = 0; i < 4; i++) begin
            m_addr[i*AW +: AW]    = AW'(32'h40 + 32'h10 * i);
            m_wr_data[i*DW +: DW] = 32'hC0DE0000 + i;
        end

        // Reset with everyone requesting: nothing granted, slave side idle.
        tick(); tick();
        chk("rst_grnt", 64'(m_grnt), 64'h0);
        chk("rst_s_as", 64'(s_as), 64'h0);
        chk("rst_s_addr", 64'(s_addr), 64'h0);
        chk("rst_m_ready", 64'(m_ready), 64'h0);
        chk("rst_rd_data", 64'(m_rd_data), 64'h0);
        rst = 1'b0; m_as = 4'h0; s_ready = 1'b0;
        tick();
        chk("post_rst_grnt", 64'(m_grnt), 64'h1);
        m_req = 4'h0;
        tick();
        chk("idle_grnt", 64'(m_grnt), 64'h0);

        // Single master read.
        m_req = 4'b0010; m_as = 4'b0010; m_addr[1*AW +: AW] = AW'(32'h100);
        tick();
        chk("single_grnt", 64'(m_grnt), 64'h2);
        chk("single_s_addr", 64'(s_addr), 64'h100);
        chk("single_noready", 64'(m_ready), 64'h0);
        s_ready = 1'b1; s_rd_data = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(m_ready), 64'h2);
        chk("single_rd_data", 64'(m_rd_data), 64'hDEADBEEF);
        tick();
        s_ready = 1'b0; m_req = 4'h0; m_as = 4'h0;
        #1;
        chk("single_ready_low", 64'(m_ready), 64'h0);
        tick();

        // Round-robin from a fresh reset; each owner drops req in its completion cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0; m_req = 4'hF; m_as = 4'hF; m_rw = 4'b0100;
        for (int i = 0; i < 4; i++) m_addr[i*AW +: AW] = AW'(32'h40 + 32'h10 * i);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grnt%0d", i), 64'(m_grnt), 64'(4'b0001 << i));
            chk($sformatf("rr_addr%0d", i), 64'(s_addr), 64'(32'h40 + 32'h10 * i));
            chk($sformatf("rr_rw%0d", i), 64'(s_rw), 64'(i == 2));
            chk($sformatf("rr_wdata%0d", i), 64'(s_wr_data), 64'(32'hC0DE0000 + i));
            s_ready = 1'b1; m_req[i] = 1'b0;
            #1;
            chk($sformatf("rr_ready%0d", i), 64'(m_ready), 64'(4'b0001 << i));
            tick();
            s_ready = 1'b0; m_as[i] = 1'b0;
        end
        chk("rr_idle", 64'(m_grnt), 64'h0);
        m_req = 4'b0001;
        tick();
        chk("rr_wrap", 64'(m_grnt), 64'h1);
        m_req = 4'h0;
        tick();

        // Hold: m0 keeps req across three transfers while m2 waits.
        m_req = 4'b0001; m_rw = 4'h0;
        tick();
        m_req = 4'b0101; m_as = 4'b0001;
        for (int t = 0; t < 3; t++) begin
            s_ready = 1'b1;
            #1;
            chk($sformatf("hold_ready%0d", t), 64'(m_ready), 64'h1);
            tick();
            s_ready = 1'b0;
            #1;
            chk($sformatf("hold_grnt%0d", t), 64'(m_grnt), 64'h1);
        end
        m_req = 4'b0100; m_as = 4'h0;
        tick();
        chk("hold_handover", 64'(m_grnt), 64'h4);
        m_req = 4'h0;
        tick();

        // Watchdog: m3 strobes a slave that never answers.
        m_req = 4'b1000; m_as = 4'b1000; s_rd_data = 32'h12345678;
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) chk("wd_rd_pass", 64'(m_rd_data), 64'h12345678);
            if (c == 7) begin
                chk("wd_err_early", 64'(m_err), 64'h0);
                chk("wd_ready_early", 64'(m_ready), 64'h0);
            end
            if (c == 8) begin
                chk("wd_err", 64'(m_err), 64'h8);
                chk("wd_ready", 64'(m_ready), 64'h8);
                chk("wd_rd_zero", 64'(m_rd_data), 64'h0);
                chk("nowd_err", 64'(z_err), 64'h0);
                chk("nowd_ready", 64'(z_ready), 64'h0);
            end else begin
                tick();
            end
        end
        tick();
        chk("wd_err_pulse", 64'(m_err), 64'h0);
        chk("wd_keep_grnt", 64'(m_grnt), 64'h8);
        m_req = 4'h0; m_as = 4'h0;
        tick();

        // Reset while m1 owns the bus mid-transfer.
        m_req = 4'b0010; m_as = 4'b0010;
        tick();
        chk("mid_grnt", 64'(m_grnt), 64'h2);
        chk("mid_s_as", 64'(s_as), 64'h1);
        rst = 1'b1; m_req = 4'b0011;
        tick();
        chk("mid_rst_grnt", 64'(m_grnt), 64'h0);
        chk("mid_rst_s_as", 64'(s_as), 64'h0);
        rst = 1'b0;
        tick();
        chk("mid_after_rst", 64'(m_grnt), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
